// File: rtl/a2b_ctrl.sv
// Sequencing front-end for the CGV14 arithmetic-to-Boolean converter: accepts masked
// shares, draws the converter's randomness from an xorshift32 generator, returns Boolean shares.
module a2b_ctrl #(
  parameter int unsigned k       = 16,
  parameter logic [31:0] SEED    = 32'h2545F491,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  seed_i,
  input  logic         seed_load_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [k-1:0] A0_i,
  input  logic [k-1:0] A1_i,
  output logic         conv_start_o,
  output logic [k-1:0] conv_A0_o,
  output logic [k-1:0] conv_A1_o,
  output logic [k-1:0] conv_R0_o,
  output logic [k-1:0] conv_R1_o,
  output logic [k-2:0] conv_Rxy_o,
  output logic [k-2:0] conv_Rxc_o,
  output logic [k-2:0] conv_Ryc_o,
  input  logic         conv_finish_i,
  input  logic [k-1:0] conv_B0_i,
  input  logic [k-1:0] conv_B1_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [k-1:0] B0_o,
  output logic [k-1:0] B1_o,
  output logic         err_o,
  output logic [15:0]  count_o
);

  localparam int unsigned RAND_W = 5 * k - 3;
  localparam int unsigned NW     = (RAND_W + 31) / 32;
  localparam int unsigned IW     = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_START, S_WAIT, S_OUT} state_e;

  function automatic logic [31:0] xs_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  state_e           state_q, state_d;
  logic [31:0]      rng_q, rng_d;
  logic [NW*32-1:0] w_q, w_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [k-1:0]     a0_q, a0_d, a1_q, a1_d;
  logic [k-1:0]     b0_q, b0_d, b1_q, b1_d;
  logic             err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rng_q   <= SEED;
      w_q     <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rng_q   <= rng_d;
      w_q     <= w_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rng_d   = rng_q;
    w_d     = w_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    a0_d    = a0_q;
    a1_d    = a1_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // Reseed takes effect on the same edge as an accept, so GEN steps from the new seed.
        if (seed_load_i) rng_d = (seed_i == '0) ? SEED : seed_i;
        if (in_valid_i) begin
          a0_d    = A0_i;
          a1_d    = A1_i;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = S_GEN;
        end
      end
      S_GEN: begin
        rng_d = xs_step(rng_q);
        for (int i = 0; i < int'(NW); i++) begin
          if (idx_q == IW'(i)) w_d[i*32 +: 32] = rng_d;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NW - 1)) state_d = S_START;
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (conv_finish_i) begin
          b0_d    = conv_B0_i;
          b1_d    = conv_B1_i;
          cnt_d   = cnt_q + 16'd1;
          state_d = S_OUT;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o   = (state_q == S_IDLE);
    conv_start_o = (state_q == S_START);
    out_valid_o  = (state_q == S_OUT);
  end

  // Randomness slices: {Ryc, Rxc, Rxy, R1, R0} is the low RAND_W bits of {w(NW-1)..w0}.
  assign conv_R0_o  = w_q[k-1:0];
  assign conv_R1_o  = w_q[2*k-1:k];
  assign conv_Rxy_o = w_q[3*k-2:2*k];
  assign conv_Rxc_o = w_q[4*k-3:3*k-1];
  assign conv_Ryc_o = w_q[5*k-4:4*k-2];

  assign conv_A0_o = a0_q;
  assign conv_A1_o = a1_q;
  assign B0_o      = b0_q;
  assign B1_o      = b1_q;
  assign err_o     = err_q;
  assign count_o   = cnt_q;

  if (NW * 32 > RAND_W) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^w_q[NW*32-1:RAND_W];
  end

endmodule

// File: tb/tb_a2b_ctrl.sv
// Directed bench for a2b_ctrl with a 3-cycle converter model and an xorshift32 reference.
module tb_a2b_ctrl;
  localparam int K = 16;
  localparam logic [31:0] SEED = 32'h2545F491;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] seed = '0;
  logic seed_load = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [K-1:0] a0 = '0, a1 = '0;
  logic conv_start;
  logic [K-1:0] conv_A0, conv_A1, conv_R0, conv_R1;
  logic [K-2:0] conv_Rxy, conv_Rxc, conv_Ryc;
  logic conv_finish;
  logic [K-1:0] conv_B0, conv_B1;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [K-1:0] b0, b1;
  logic err;
  logic [15:0] count;

  int total = 0;
  int bad = 0;
  logic [31:0] ref_rng;

  // converter model: finish three cycles after start, Boolean shares masked by mb0
  logic fin_en = 1'b1;
  logic stray_fin = 1'b0;
  logic [K-1:0] stray_b = '0;
  logic [2:0] sr;
  logic [K-1:0] mb0;
  logic [K-1:0] asum;
  logic [76:0] rand_obs;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      mb0 <= '0;
    end else begin
      sr <= {sr[1:0], conv_start};
      if (conv_start) mb0 <= K'($urandom);
    end
  end

  assign asum        = conv_A0 + conv_A1;
  assign conv_finish = (sr[2] & fin_en) | stray_fin;
  assign conv_B0     = stray_fin ? stray_b : mb0;
  assign conv_B1     = stray_fin ? stray_b : (asum ^ mb0);
  assign rand_obs    = {conv_Ryc, conv_Rxc, conv_Rxy, conv_R1, conv_R0};

  a2b_ctrl #(.k(K), .SEED(SEED), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .seed_i(seed), .seed_load_i(seed_load),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .A0_i(a0), .A1_i(a1),
    .conv_start_o(conv_start), .conv_A0_o(conv_A0), .conv_A1_o(conv_A1),
    .conv_R0_o(conv_R0), .conv_R1_o(conv_R1), .conv_Rxy_o(conv_Rxy),
    .conv_Rxc_o(conv_Rxc), .conv_Ryc_o(conv_Ryc), .conv_finish_i(conv_finish),
    .conv_B0_i(conv_B0), .conv_B1_i(conv_B1), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .B0_o(b0), .B1_o(b1), .err_o(err), .count_o(count)
  );

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  task automatic gen_rand(input logic [31:0] s, output logic [76:0] r, output logic [31:0] s_next);
    logic [95:0] w;
    logic [31:0] x;
    x = s;
    for (int i = 0; i < 3; i++) begin
      x = xs(x);
      w[i*32 +: 32] = x;
    end
    r = w[76:0];
    s_next = x;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [K-1:0] x0, input logic [K-1:0] x1);
    a0 = x0;
    a1 = x1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%h want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%h want=0", out_valid); end
    total++; if (conv_start !== 1'b0) begin bad++; $display("FAIL reset_conv_start got=%h want=0", conv_start); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%h want=0", err); end
    total++; if (count !== 16'd0) begin bad++; $display("FAIL reset_count got=%h want=0", count); end
    total++; if ({b0, b1, rand_obs} !== '0) begin bad++; $display("FAIL reset_data got=%h/%h/%h want=0", b0, b1, rand_obs); end
    rst = 1'b0;
    tick();
    ref_rng = SEED;
  endtask

  task automatic test_basic();
    logic [76:0] er;
    int cyc;
    seed = 32'd1; seed_load = 1'b1; tick(); seed_load = 1'b0;
    ref_rng = 32'd1;
    accept(16'h1234, 16'h0001);
    tick(); tick(); tick();
    total++; if (conv_start !== 1'b1) begin bad++; $display("FAIL basic_start got=%h want=1", conv_start); end
    total++; if ({conv_R1, conv_R0} !== 32'h00042021) begin bad++; $display("FAIL basic_w0 got=%h want=00042021", {conv_R1, conv_R0}); end
    gen_rand(ref_rng, er, ref_rng);
    total++; if (rand_obs !== er) begin bad++; $display("FAIL basic_rand got=%h want=%h", rand_obs, er); end
    total++; if ({conv_A0, conv_A1} !== 32'h12340001) begin bad++; $display("FAIL basic_conv_a got=%h want=12340001", {conv_A0, conv_A1}); end
    tick();
    total++; if (conv_start !== 1'b0) begin bad++; $display("FAIL basic_start_pulse got=%h want=0", conv_start); end
    cyc = 5;
    while (cyc < 40 && out_valid !== 1'b1) begin tick(); cyc++; end
    total++; if (cyc !== 8) begin bad++; $display("FAIL basic_latency got=%0d want=8", cyc); end
    total++; if ((b0 ^ b1) !== 16'h1235) begin bad++; $display("FAIL basic_xor got=%h want=1235", b0 ^ b1); end
    total++; if (count !== 16'd1) begin bad++; $display("FAIL basic_count got=%0d want=1", count); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%h want=1", in_ready); end
  endtask

  task automatic test_wrap();
    logic [76:0] er;
    logic [K-1:0] hb0, hb1;
    int cyc;
    accept(16'hFFFF, 16'h0002);
    tick(); tick(); tick();
    gen_rand(ref_rng, er, ref_rng);
    total++; if (rand_obs !== er) begin bad++; $display("FAIL wrap_rand got=%h want=%h", rand_obs, er); end
    cyc = 4;
    while (cyc < 40 && out_valid !== 1'b1) begin tick(); cyc++; end
    total++; if (cyc !== 8) begin bad++; $display("FAIL wrap_latency got=%0d want=8", cyc); end
    hb0 = b0; hb1 = b1;
    total++; if ((hb0 ^ hb1) !== 16'h0001) begin bad++; $display("FAIL wrap_xor got=%h want=0001", hb0 ^ hb1); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({out_valid, in_ready, b0, b1} !== {1'b1, 1'b0, hb0, hb1}) begin
        bad++; $display("FAIL wrap_hold%0d got=%h want=%h", i, {out_valid, in_ready, b0, b1}, {1'b1, 1'b0, hb0, hb1});
      end
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL wrap_release got=%b want=10", {in_ready, out_valid}); end
    total++; if (count !== 16'd2) begin bad++; $display("FAIL wrap_count got=%0d want=2", count); end
  endtask

  task automatic test_seed_zero();
    logic [76:0] er;
    int cyc;
    seed = 32'd0; seed_load = 1'b1;
    accept(16'h0F0F, 16'h7001);
    seed_load = 1'b0;
    ref_rng = SEED;
    tick(); tick(); tick();
    total++; if ({conv_R1, conv_R0} !== xs(SEED)) begin bad++; $display("FAIL seed0_w0 got=%h want=%h", {conv_R1, conv_R0}, xs(SEED)); end
    gen_rand(ref_rng, er, ref_rng);
    total++; if (rand_obs !== er) begin bad++; $display("FAIL seed0_rand got=%h want=%h", rand_obs, er); end
    cyc = 4;
    while (cyc < 40 && out_valid !== 1'b1) begin tick(); cyc++; end
    total++; if ((b0 ^ b1) !== 16'h7F10) begin bad++; $display("FAIL seed0_xor got=%h want=7F10", b0 ^ b1); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_timeout();
    logic [76:0] er;
    logic [15:0] c0;
    logic seen_valid;
    int cyc;
    fin_en = 1'b0;
    c0 = count;
    accept(16'h0042, 16'h0100);
    seed = 32'hDEADBEEF; seed_load = 1'b1;
    tick(); tick(); tick(); tick();
    seed_load = 1'b0;
    gen_rand(ref_rng, er, ref_rng);
    cyc = 5; seen_valid = 1'b0;
    while (cyc < 60 && err !== 1'b1) begin
      if (out_valid === 1'b1) seen_valid = 1'b1;
      tick(); cyc++;
    end
    total++; if (cyc !== 20) begin bad++; $display("FAIL timeout_cycle got=%0d want=20", cyc); end
    total++; if ({err, in_ready, seen_valid} !== 3'b110) begin bad++; $display("FAIL timeout_state got=%b want=110", {err, in_ready, seen_valid}); end
    total++; if (count !== c0) begin bad++; $display("FAIL timeout_count got=%0d want=%0d", count, c0); end
    fin_en = 1'b1;
    accept(16'h1111, 16'h2222);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL timeout_err_clear got=%h want=0", err); end
    tick(); tick(); tick();
    gen_rand(ref_rng, er, ref_rng);
    total++; if (rand_obs !== er) begin bad++; $display("FAIL timeout_rand got=%h want=%h", rand_obs, er); end
    cyc = 4;
    while (cyc < 40 && out_valid !== 1'b1) begin tick(); cyc++; end
    total++; if ((b0 ^ b1) !== 16'h3333) begin bad++; $display("FAIL timeout_xor got=%h want=3333", b0 ^ b1); end
    total++; if (count !== c0 + 16'd1) begin bad++; $display("FAIL timeout_count2 got=%0d want=%0d", count, c0 + 16'd1); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    accept(16'hABCD, 16'h1357);
    tick(); tick(); tick();
    total++; if (conv_start !== 1'b1) begin bad++; $display("FAIL rstmid_start got=%h want=1", conv_start); end
    rst = 1'b1;
    #1;
    total++; if ({conv_start, out_valid, in_ready} !== 3'b001) begin bad++; $display("FAIL rstmid_async got=%b want=001", {conv_start, out_valid, in_ready}); end
    total++; if (count !== 16'd0) begin bad++; $display("FAIL rstmid_count got=%0d want=0", count); end
    tick();
    rst = 1'b0;
    ref_rng = SEED;
    tick();
    stray_b = 16'h5A5A; stray_fin = 1'b1;
    tick();
    stray_fin = 1'b0;
    total++; if ({out_valid, in_ready, count, b0} !== {1'b0, 1'b1, 16'd0, 16'd0}) begin
      bad++; $display("FAIL rstmid_stray got=%h want=%h", {out_valid, in_ready, count, b0}, {1'b0, 1'b1, 16'd0, 16'd0});
    end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stray_late got=%h want=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [76:0] er;
    logic [31:0] r32;
    logic [K-1:0] va, vb, es;
    int cyc;
    out_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      r32 = $urandom; va = r32[15:0]; vb = r32[31:16];
      es = va + vb;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready n=%0d got=%h want=1", n, in_ready); end
      accept(va, vb);
      cyc = 0;
      while (cyc < 10 && conv_start !== 1'b1) begin tick(); cyc++; end
      gen_rand(ref_rng, er, ref_rng);
      total++; if (rand_obs !== er) begin bad++; $display("FAIL b2b_rand n=%0d got=%h want=%h", n, rand_obs, er); end
      cyc = 0;
      while (cyc < 20 && out_valid !== 1'b1) begin tick(); cyc++; end
      total++; if ((b0 ^ b1) !== es || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_xor n=%0d got=%h want=%h", n, b0 ^ b1, es); end
      tick();
    end
    out_ready = 1'b0;
    total++; if (count !== 16'd1000) begin bad++; $display("FAIL b2b_count got=%0d want=1000", count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_seed_zero();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/a2b_ctrl.md
Name: a2b_ctrl

Overview:
- Sequencing front-end that sits directly upstream of the CGV14 arithmetic-to-Boolean converter.
- Accepts one arithmetic-masked value (A0 + A1 mod 2^k) per transaction over a valid/ready handshake.
- Generates the converter's fresh randomness (R0, R1, Rxy, Rxc, Ryc) from an internal xorshift32 generator, pulses the converter's start, and waits for its finish.
- Captures the Boolean shares and presents them downstream over a valid/ready handshake.

Parameters:
- k, 16, share width; must match the converter.
- SEED, 32'h2545F491, reset/fallback generator state; must be nonzero.
- TIMEOUT, 15, maximum WAIT cycles before abort.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- seed_i  in  32  generator reseed value
- seed_load_i  in  1  reseed strobe; honoured only in IDLE
- in_valid_i  in  1  input share pair valid
- in_ready_o  out  1  controller can accept
- A0_i, A1_i  in  k each  arithmetic shares
- conv_start_o  out  1  one-cycle start pulse to converter
- conv_A0_o, conv_A1_o  out  k each  held arithmetic shares
- conv_R0_o, conv_R1_o  out  k each  randomness
- conv_Rxy_o, conv_Rxc_o, conv_Ryc_o  out  k-1 each  randomness
- conv_finish_i  in  1  converter finish
- conv_B0_i, conv_B1_i  in  k each  converter Boolean shares
- out_valid_o  out  1  Boolean shares valid
- out_ready_i  in  1  downstream accepts
- B0_o, B1_o  out  k each  captured Boolean shares
- err_o  out  1  sticky timeout flag
- count_o  out  16  completed conversions, wraps at 2^16

Behaviour:
- RAND_W = 5k-3; NW = ceil(RAND_W/32), which is 3 for k=16.
- Randomness buffer: NW 32-bit words w0..w(NW-1), with w0 generated first. {Ryc, Rxc, Rxy, R1, R0} = low RAND_W bits of {w(NW-1), ..., w0}, so R0 = w0[k-1:0].
- Generator step: x ^= x<<13; x ^= x>>17; x ^= x<<5 (32-bit).
- Reset state: rng = SEED, all data registers 0, state IDLE. Outputs: in_ready_o=1, out_valid_o=0, conv_start_o=0, err_o=0, count_o=0.
- Reseed: seed_load_i in IDLE sets rng = seed_i, or SEED if seed_i==0. In other states seed_load_i is ignored. If seed_load_i and an accept occur in the same cycle, the reseed applies first; generation uses the new seed.
- FSM states: IDLE, GEN, START, WAIT, OUT.
  - IDLE: in_ready_o=1. On in_valid_i: capture A0/A1, clear err_o, go to GEN with word index 0.
  - GEN: NW cycles. Each cycle rng <= step(rng) and w[idx] <= step(rng). Go to START after idx = NW-1.
  - START: conv_start_o=1 for exactly one cycle, then WAIT with the timeout counter cleared.
  - WAIT: on conv_finish_i, capture conv_B0_i/conv_B1_i into B0_o/B1_o, increment count_o, go to OUT. If the counter reaches TIMEOUT without finish: set err_o, go to IDLE, out_valid_o stays 0.
  - OUT: out_valid_o=1 with B0_o/B1_o stable until out_ready_i, then go to IDLE. There is no same-cycle bypass; in_ready_o rises the cycle after the OUT handshake.
- conv_A*_o and conv_R*_o are registered and stay stable from START until the next acceptance.
- conv_finish_i is ignored outside WAIT.
- Nominal latency, with the converter taking 3 cycles after start: acceptance in cycle 0, GEN cycles 1..NW, START cycle NW+1, finish in cycle NW+4, out_valid_o in cycle NW+5 (cycle 8 for k=16).
- Reset asserted mid-transaction: immediate return to IDLE and reset values, with conv_start_o deasserted asynchronously. In-flight data is discarded.
- Correctness invariant: B0_o ^ B1_o == (A0 + A1) mod 2^k.
- No unmasked value (A0+A1 or B0^B1) is ever formed or registered inside the block.

Test Plan:
- Reset, then seed_load_i with seed_i=1, then accept A0=0x1234, A1=0x0001 -> w0=0x00042021, conv_R0_o=0x2021, conv_R1_o=0x0004; out_valid_o in cycle 8; B0_o^B1_o=0x1235; count_o=1.
- Wrap case A0=0xFFFF, A1=0x0002 with out_ready_i held low for 5 cycles -> B0_o^B1_o=0x0001; out_valid_o and B0_o/B1_o stable throughout; in_ready_o=1 one cycle after the handshake.
- Reseed with seed_i=0 -> generator loads SEED; first word equals step(0x2545F491).
- Converter model that never asserts finish -> err_o=1 after TIMEOUT WAIT cycles, state returns to IDLE, count_o unchanged; the next acceptance clears err_o.
- Assert rst_i during WAIT -> conv_start_o=0, out_valid_o=0, count_o=0; a stray conv_finish_i in IDLE is ignored.
- 1000 back-to-back random A0/A1 with a reference xorshift model -> all XOR checks pass, randomness matches the model, count_o=1000.
